// File: rtl/comb_decim_seq.sv
// Purpose: word-serial CIC comb + decimator; emits x[k]-x[k-1] for every DECIM-th sample.
// Latency: one clock from an accepted input word to the matching data_out word.
// Backpressure: hold=1 stalls all state; out_valid/out_LSB_flag drop, data_out holds.
//
// Ports:
//   clock, reset (async active-low)
//   data_in      serial input word, LSB word of each sample first
//   hold         stall; the input word and LSB_flag are ignored
//   LSB_flag     data_in is word 0 of a new sample
//   data_out     registered difference word
//   out_valid    data_out carries a new word this cycle
//   out_LSB_flag data_out is word 0 of an output sample
//   sync_err     one-cycle pulse on a framing error
module comb_decim_seq #(
  parameter int word_length = 8,
  parameter int latency     = 4,
  parameter int DECIM       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [word_length-1:0] data_in,
  input  logic                   hold,
  input  logic                   LSB_flag,
  output logic [word_length-1:0] data_out,
  output logic                   out_valid,
  output logic                   out_LSB_flag,
  output logic                   sync_err
);

  localparam int CW = (latency > 1) ? $clog2(latency) : 1;
  localparam int SW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] WORD_LAST = CW'(latency - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(DECIM - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          word_cnt_q, word_cnt_d;
  logic [SW-1:0]          samp_cnt_q, samp_cnt_d;
  logic                   borrow_q, borrow_d;
  logic [word_length-1:0] store_q [latency];
  logic [word_length-1:0] store_d [latency];
  logic [word_length-1:0] data_out_q, data_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_lsb_q, out_lsb_d;
  logic                   sync_err_q, sync_err_d;

  // Per-word datapath helpers
  logic                   accept;
  logic [CW-1:0]          wi;
  logic                   bin;
  logic [word_length:0]   diff;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    borrow_d    = borrow_q;
    store_d     = store_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    out_lsb_d   = 1'b0;
    sync_err_d  = 1'b0;
    accept      = 1'b0;
    wi          = word_cnt_q;
    bin         = 1'b0;
    diff        = '0;

    if (!hold) begin
      if (state_q == SYNC) begin
        if (LSB_flag) begin
          accept  = 1'b1;
          wi      = '0;
          state_d = RUN;
        end
      end else begin
        if (LSB_flag && (word_cnt_q != '0)) begin
          // Early LSB: drop the partial sample and restart framing on this word.
          sync_err_d = 1'b1;
          accept     = 1'b1;
          wi         = '0;
        end else if (!LSB_flag && (word_cnt_q == '0)) begin
          // Missing LSB: lose lock, discard the word.
          sync_err_d = 1'b1;
          state_d    = SYNC;
        end else begin
          accept = 1'b1;
          wi     = word_cnt_q;
        end
      end
    end

    if (accept) begin
      if (samp_cnt_q == SAMP_LAST) begin
        // Borrow chains across words of the sample; word 0 starts fresh.
        bin         = (wi == '0) ? 1'b0 : borrow_q;
        diff        = {1'b0, data_in} - {1'b0, store_q[wi]}
                    - {{word_length{1'b0}}, bin};
        data_out_d  = diff[word_length-1:0];
        borrow_d    = diff[word_length];
        store_d[wi] = data_in;
        out_valid_d = 1'b1;
        out_lsb_d   = (wi == '0);
      end
      if (wi == WORD_LAST) begin
        word_cnt_d = '0;
        samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + SW'(1);
      end else begin
        word_cnt_d = wi + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= SYNC;
      word_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      borrow_q    <= 1'b0;
      for (int i = 0; i < latency; i++) store_q[i] <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_lsb_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      borrow_q    <= borrow_d;
      store_q     <= store_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_lsb_q   <= out_lsb_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign data_out     = data_out_q;
  assign out_valid    = out_valid_q;
  assign out_LSB_flag = out_lsb_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_comb_decim_seq.sv
module tb_comb_decim_seq;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       hold;
  logic       LSB_flag;

  logic [7:0] d1, d4;
  logic       v1, v4, l1, l4, e1, e4;

  int n_cmp = 0;
  int n_err = 0;

  comb_decim_seq #(.word_length(8), .latency(4), .DECIM(1)) u1 (
    .clock(clock), .reset(reset), .data_in(data_in), .hold(hold),
    .LSB_flag(LSB_flag), .data_out(d1), .out_valid(v1),
    .out_LSB_flag(l1), .sync_err(e1)
  );

  comb_decim_seq #(.word_length(8), .latency(4), .DECIM(4)) u4 (
    .clock(clock), .reset(reset), .data_in(data_in), .hold(hold),
    .LSB_flag(LSB_flag), .data_out(d4), .out_valid(v4),
    .out_LSB_flag(l4), .sync_err(e4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word, step one edge, then check the selected DUT (sel=0: DECIM=1, sel=1: DECIM=4).
  task automatic word(input string tag, input bit sel, input logic [7:0] d, input logic lsb,
                      input logic exp_vld, input logic [7:0] exp_dat,
                      input logic exp_lsb, input logic exp_err);
    hold     = 1'b0;
    data_in  = d;
    LSB_flag = lsb;
    @(posedge clock);
    #1;
    chk({tag, ".vld"}, {31'd0, sel ? v4 : v1}, {31'd0, exp_vld});
    chk({tag, ".lsb"}, {31'd0, sel ? l4 : l1}, {31'd0, exp_lsb});
    chk({tag, ".err"}, {31'd0, sel ? e4 : e1}, {31'd0, exp_err});
    if (exp_vld) chk({tag, ".dat"}, {24'd0, sel ? d4 : d1}, {24'd0, exp_dat});
  endtask

  task automatic samp(input string tag, input bit sel, input logic [31:0] x,
                      input logic [31:0] y, input logic vld);
    for (int i = 0; i < 4; i++)
      word($sformatf("%s.w%0d", tag, i), sel, x[8*i +: 8], (i == 0),
           vld, y[8*i +: 8], vld && (i == 0), 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    hold     = 1'b0;
    LSB_flag = 1'b0;
    data_in  = 8'h00;
    #1;
    chk("rst.d1", {24'd0, d1}, 32'd0);
    chk("rst.v1", {31'd0, v1}, 32'd0);
    chk("rst.l1", {31'd0, l1}, 32'd0);
    chk("rst.e1", {31'd0, e1}, 32'd0);
    chk("rst.v4", {31'd0, v4}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // 1: asynchronous reset while out_valid is high
    word("t1.pre", 0, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("t1.async.d", {24'd0, d1}, 32'd0);
    chk("t1.async.v", {31'd0, v1}, 32'd0);
    chk("t1.async.l", {31'd0, l1}, 32'd0);
    #1 reset = 1'b1;
    word("t1.nolsb0", 0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    word("t1.nolsb1", 0, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 2: DECIM=1, first sample differs from an empty store
    samp("t2.s0", 0, 32'h0000_0010, 32'h0000_0010, 1'b1);
    samp("t2.s1", 0, 32'h0000_0020, 32'h0000_0010, 1'b1);
    samp("t2.s2", 0, 32'h0000_0030, 32'h0000_0010, 1'b1);

    // 3: borrow chain across words
    samp("t3.prev", 0, 32'h0000_00FF, 32'h0000_00CF, 1'b1);
    samp("t3.curr", 0, 32'h0000_0100, 32'h0000_0001, 1'b1);

    // 4: modulo wrap
    samp("t4.prev", 0, 32'hFFFF_FFF0, 32'hFFFF_FEF0, 1'b1);
    samp("t4.curr", 0, 32'h0000_0010, 32'h0000_0020, 1'b1);

    // 5: DECIM=4, only samples 3 and 7 emitted
    do_reset();
    for (int n = 0; n < 8; n++) begin
      if (n == 3)      samp("t5.s3", 1, 32'h30, 32'h30, 1'b1);
      else if (n == 7) samp("t5.s7", 1, 32'h70, 32'h40, 1'b1);
      else             samp($sformatf("t5.s%0d", n), 1, 32'(n * 16), 32'd0, 1'b0);
    end

    // 6a: hold between words 1 and 2 (u1 store holds 0x70)
    word("t6.h.w0", 0, 8'h34, 1'b1, 1'b1, 8'hC4, 1'b1, 1'b0);
    word("t6.h.w1", 0, 8'h12, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      hold     = 1'b1;
      LSB_flag = 1'b1;
      data_in  = 8'hAA;
      @(posedge clock);
      #1;
      chk($sformatf("t6.hold%0d.vld", c), {31'd0, v1}, 32'd0);
      chk($sformatf("t6.hold%0d.dat", c), {24'd0, d1}, 32'h11);
      chk($sformatf("t6.hold%0d.lsb", c), {31'd0, l1}, 32'd0);
    end
    word("t6.h.w2", 0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    word("t6.h.w3", 0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // 6b: early LSB_flag at word_cnt=2 (store now 0x00001234)
    word("t6.f.w0", 0, 8'h78, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
    word("t6.f.w1", 0, 8'h56, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
    // store is now {00,00,56,78}; new sample 0x00009ABC restarts as word 0
    word("t6.f.n0", 0, 8'hBC, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
    word("t6.f.n1", 0, 8'h9A, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
    word("t6.f.n2", 0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    word("t6.f.n3", 0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // 6c: missing LSB_flag at word 0 -> error, drop to SYNC, words ignored until LSB
    word("t6.m.bad", 0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    word("t6.m.ign", 0, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    samp("t6.m.resync", 0, 32'h0000_A0C0, 32'h0000_0604, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
